// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
// Package  : bus_pkg
// Shared FSM states, burst mode encodings and LFSR taps for traffic_master.
// Revision : 1.0
// ============================================================================
package bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_CHECK  = 3'd3,
    ST_NEXTPH = 3'd4,
    ST_FIN    = 3'd5
  } state_t;

  localparam logic [1:0] MODE_WR  = 2'b00;
  localparam logic [1:0] MODE_RD  = 2'b01;
  localparam logic [1:0] MODE_WRV = 2'b10;

  localparam logic [7:0] PATTERN_BASE = 8'hA5;

  // Right-shifting Galois taps; maximal-length where a known value exists.
  function automatic logic [31:0] lfsr_taps(input int width);
    case (width)
      4:       return 32'h0000_0009;
      5:       return 32'h0000_0012;
      6:       return 32'h0000_0021;
      7:       return 32'h0000_0041;
      8:       return 32'h0000_00B8;
      16:      return 32'h0000_B400;
      32:      return 32'h8020_0003;
      default: return (32'h1 << (width - 1)) | 32'h1;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/traffic_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : traffic_pattern_gen
// Data pattern source: incrementing from 0xA5, or a Galois LFSR seeded with 1
// when TRAFFIC_MASTER_LFSR_EN is defined. Revision : 1.0
// ============================================================================
module traffic_pattern_gen
  import bus_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  seed,
  input  logic                  step,
  output logic [DATA_WIDTH-1:0] value
);

  logic [DATA_WIDTH-1:0] value_q, value_d;

`ifdef TRAFFIC_MASTER_LFSR_EN
  localparam logic [DATA_WIDTH-1:0] TAPS = DATA_WIDTH'(lfsr_taps(DATA_WIDTH));

  always_comb begin
    value_d = value_q;
    if (seed) begin
      value_d = DATA_WIDTH'(1);
    end else if (step) begin
      value_d = (value_q >> 1) ^ (value_q[0] ? TAPS : '0);
    end
  end
`else
  always_comb begin
    value_d = value_q;
    if (seed) begin
      value_d = DATA_WIDTH'(PATTERN_BASE);
    end else if (step) begin
      value_d = value_q + DATA_WIDTH'(1);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule
`default_nettype wire

// File: rtl/traffic_master.sv
`default_nettype none
// ============================================================================
// Module   : traffic_master
// Burst write / read / write+verify traffic generator, round-robin over slaves.
// TRAFFIC_MASTER_LFSR_EN selects LFSR data.  Revision : 1.0
// ============================================================================
module traffic_master
  import bus_pkg::*;
#(
  parameter int ADDR_WIDTH           = 16,
  parameter int DATA_WIDTH           = 8,
  parameter int SLAVE_MEM_ADDR_WIDTH = 12,
  parameter int SLAVE_COUNT          = 3,
  parameter int LEN_WIDTH            = 8,
  parameter int TIMEOUT_CYCLES       = 1024
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [1:0]                      mode,
  input  logic [LEN_WIDTH-1:0]            burst_len,
  input  logic [SLAVE_MEM_ADDR_WIDTH-1:0] base_off,
  output logic                            ready,
  output logic                            done,
  output logic [15:0]                     err_count,
  output logic                            timeout,
  output logic [ADDR_WIDTH-1:0]           daddr,
  output logic [DATA_WIDTH-1:0]           dwdata,
  input  logic [DATA_WIDTH-1:0]           drdata,
  output logic                            dmode,
  output logic                            dvalid,
  input  logic                            dready
);

  localparam int SID_W = ADDR_WIDTH - SLAVE_MEM_ADDR_WIDTH;
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SID_W-1:0] SID_LAST = SID_W'(SLAVE_COUNT - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  state_t                          state_q, state_d;
  logic [1:0]                      mode_q, mode_d;
  logic [LEN_WIDTH-1:0]            len_q, len_d, idx_q, idx_d;
  logic [SLAVE_MEM_ADDR_WIDTH-1:0] base_q, base_d, off_q, off_d;
  logic [SID_W-1:0]                sid_q, sid_d;
  logic                            dmode_q, dmode_d, dvalid_q, dvalid_d;
  logic                            tout_q, tout_d, dready_q;
  logic [TMR_W-1:0]                timer_q, timer_d;
  logic [DATA_WIDTH-1:0]           rdata_q, rdata_d, pat_value;
  logic [15:0]                     err_q, err_d;
  logic                            pat_seed, pat_step, xfer_done, verify_rd;

  traffic_pattern_gen #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_pattern (
    .clk  (clk),
    .rst  (rst),
    .seed (pat_seed),
    .step (pat_step),
    .value(pat_value)
  );

  assign verify_rd = (mode_q == MODE_WRV) && !dmode_q;

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    len_d     = len_q;
    base_d    = base_q;
    idx_d     = idx_q;
    sid_d     = sid_q;
    off_d     = off_q;
    dmode_d   = dmode_q;
    dvalid_d  = 1'b0;
    tout_d    = tout_q;
    timer_d   = timer_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    pat_seed  = 1'b0;
    pat_step  = 1'b0;
    xfer_done = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d   = (mode == 2'b11) ? MODE_RD : mode;
          len_d    = (burst_len == '0) ? LEN_WIDTH'(1) : burst_len;
          base_d   = base_off;
          off_d    = base_off;
          idx_d    = '0;
          sid_d    = '0;
          err_d    = '0;
          tout_d   = 1'b0;
          dmode_d  = (mode == MODE_WR) || (mode == MODE_WRV);
          pat_seed = 1'b1;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (dready) begin
          dvalid_d = 1'b1;
          timer_d  = '0;
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // dready was high on issue, so a rising edge marks the slave finishing.
        if (dready && !dready_q) begin
          rdata_d = drdata;
          if (verify_rd) state_d = ST_CHECK;
          else           xfer_done = 1'b1;
        end else if (timer_q == TMR_LAST) begin
          tout_d    = 1'b1;
          xfer_done = 1'b1;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      ST_CHECK: begin
        if ((rdata_q != pat_value) && (err_q != 16'hFFFF)) err_d = err_q + 16'd1;
        xfer_done = 1'b1;
      end
      ST_NEXTPH: begin
        idx_d    = '0;
        sid_d    = '0;
        off_d    = base_q;
        dmode_d  = 1'b0;
        pat_seed = 1'b1;
        state_d  = ST_ISSUE;
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (xfer_done) begin
      if (idx_q == len_q - LEN_WIDTH'(1)) begin
        state_d = ((mode_q == MODE_WRV) && dmode_q) ? ST_NEXTPH : ST_FIN;
      end else begin
        idx_d    = idx_q + LEN_WIDTH'(1);
        pat_step = 1'b1;
        state_d  = ST_ISSUE;
        if (sid_q == SID_LAST) begin
          sid_d = '0;
          off_d = off_q + SLAVE_MEM_ADDR_WIDTH'(1);
        end else begin
          sid_d = sid_q + SID_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      mode_q   <= MODE_WR;
      len_q    <= LEN_WIDTH'(1);
      base_q   <= '0;
      idx_q    <= '0;
      sid_q    <= '0;
      off_q    <= '0;
      dmode_q  <= 1'b0;
      dvalid_q <= 1'b0;
      tout_q   <= 1'b0;
      timer_q  <= '0;
      rdata_q  <= '0;
      err_q    <= '0;
      dready_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      len_q    <= len_d;
      base_q   <= base_d;
      idx_q    <= idx_d;
      sid_q    <= sid_d;
      off_q    <= off_d;
      dmode_q  <= dmode_d;
      dvalid_q <= dvalid_d;
      tout_q   <= tout_d;
      timer_q  <= timer_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      dready_q <= dready;
    end
  end

  assign ready     = (state_q == ST_IDLE);
  assign done      = (state_q == ST_FIN);
  assign err_count = err_q;
  assign timeout   = tout_q;
  assign daddr     = {sid_q, off_q};
  assign dwdata    = pat_value;
  assign dmode     = dmode_q;
  assign dvalid    = dvalid_q;

endmodule
`default_nettype wire
